// File: rtl/trace_arbiter.sv
// Round-robin arbiter sharing one trace sink among per-stage tracker slots.
// Optional TRACE_ARB_DROP_COUNT_EN adds saturating per-requester drop counters.
module trace_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 256,
   parameter int SRC_W      = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]            req_ready_i,
   output logic [DATA_WIDTH-1:0]         out_data_o,
   output logic [SRC_W-1:0]              out_src_o,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [NUM_REQ-1:0]            overflow_o,
   input  logic                          clear_overflow_i,
   output logic                          busy_o
`ifdef TRACE_ARB_DROP_COUNT_EN
   ,
   output logic [NUM_REQ*16-1:0]         drop_count_o
`endif
);

   localparam int IW = SRC_W + 1;

   typedef enum logic {IDLE, PRESENT} state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [DATA_WIDTH-1:0]   r_slot [NUM_REQ];
   logic [NUM_REQ-1:0]      r_slot_vld;
   logic [DATA_WIDTH-1:0]   r_data;
   logic [SRC_W-1:0]        r_src;
   logic [SRC_W-1:0]        r_rr;
   logic [NUM_REQ-1:0]      r_ovf;
   logic                    r_busy;

   logic [IW-1:0]           w_idx;
   logic [SRC_W-1:0]        w_gnt;
   logic [SRC_W-1:0]        w_rr_nxt;
   logic                    w_any;
   logic                    w_load;
   logic [NUM_REQ-1:0]      w_take;
   logic [NUM_REQ-1:0]      w_cap;
   logic [NUM_REQ-1:0]      w_drop;
   logic [NUM_REQ-1:0]      w_slot_vld_nxt;
   logic                    w_busy_nxt;

   // Walk down so the candidate nearest rr_ptr is the last one written.
   always_comb begin
      w_idx = '0;
      w_gnt = '0;
      w_any = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_idx = {1'b0, r_rr} + IW'(k);
         if (w_idx >= IW'(NUM_REQ))
            w_idx = w_idx - IW'(NUM_REQ);
         if (r_slot_vld[w_idx[SRC_W-1:0]]) begin
            w_gnt = w_idx[SRC_W-1:0];
            w_any = 1'b1;
         end
      end
   end

   assign w_rr_nxt = (w_gnt == SRC_W'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_any) begin
               w_load      = 1'b1;
               w_state_nxt = PRESENT;
            end
         end
         PRESENT: begin
            if (out_ready_i) begin
               if (w_any)
                  w_load = 1'b1;
               else
                  w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_take         = '0;
      w_cap          = '0;
      w_drop         = '0;
      w_slot_vld_nxt = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_take[i] = w_load && (w_gnt == SRC_W'(i));
         w_cap[i]  = req_ready_i[i] && (!r_slot_vld[i] || w_take[i]);
         w_drop[i] = req_ready_i[i] && r_slot_vld[i] && !w_take[i];
         w_slot_vld_nxt[i] = w_cap[i] || (r_slot_vld[i] && !w_take[i]);
      end
      w_busy_nxt = (|w_slot_vld_nxt) || (w_state_nxt == PRESENT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REQ; i++)
            r_slot[i] <= '0;
         r_slot_vld <= '0;
         r_data     <= '0;
         r_src      <= '0;
         r_rr       <= '0;
         r_ovf      <= '0;
         r_busy     <= 1'b0;
      end else begin
         if (w_load) begin
            r_data <= r_slot[w_gnt];
            r_src  <= w_gnt;
            r_rr   <= w_rr_nxt;
         end
         for (int i = 0; i < NUM_REQ; i++)
            if (w_cap[i])
               r_slot[i] <= req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
         r_slot_vld <= w_slot_vld_nxt;
         // A drop in the clearing cycle still leaves the flag set.
         r_ovf      <= (clear_overflow_i ? '0 : r_ovf) | w_drop;
         r_busy     <= w_busy_nxt;
      end
   end

`ifdef TRACE_ARB_DROP_COUNT_EN
   logic [15:0] r_cnt [NUM_REQ];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REQ; i++)
            r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (clear_overflow_i)
               r_cnt[i] <= w_drop[i] ? 16'd1 : 16'd0;
            else if (w_drop[i] && r_cnt[i] != 16'hFFFF)
               r_cnt[i] <= r_cnt[i] + 16'd1;
         end
      end
   end

   always_comb begin
      drop_count_o = '0;
      for (int i = 0; i < NUM_REQ; i++)
         drop_count_o[i*16 +: 16] = r_cnt[i];
   end
`endif

   assign out_data_o  = r_data;
   assign out_src_o   = r_src;
   assign out_valid_o = (r_state == PRESENT);
   assign overflow_o  = r_ovf;
   assign busy_o      = r_busy;

endmodule

// File: tb/tb_trace_arbiter.sv
// Randomized and directed bench for trace_arbiter against a slot/queue model.
module tb_trace_arbiter;

   localparam int N  = 4;
   localparam int DW = 256;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [N*DW-1:0] req_data_i = '0;
   logic [N-1:0]    req_ready_i = '0;
   logic [DW-1:0]   out_data_o;
   logic [1:0]      out_src_o;
   logic            out_valid_o;
   logic            out_ready_i = 1'b0;
   logic [N-1:0]    overflow_o;
   logic            clear_overflow_i = 1'b0;
   logic            busy_o;
`ifdef TRACE_ARB_DROP_COUNT_EN
   logic [N*16-1:0] drop_count_o;
`endif

   int n_chk = 0;
   int n_err = 0;

   logic [DW-1:0] m_slot [N];
   bit            m_full [N];
   bit            m_ov;
   logic [DW-1:0] m_od;
   int            m_os;
   int            m_ptr;
   logic [N-1:0]  m_ovf;

   trace_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
      .clk              (clk),
      .rst              (rst),
      .req_data_i       (req_data_i),
      .req_ready_i      (req_ready_i),
      .out_data_o       (out_data_o),
      .out_src_o        (out_src_o),
      .out_valid_o      (out_valid_o),
      .out_ready_i      (out_ready_i),
      .overflow_o       (overflow_o),
      .clear_overflow_i (clear_overflow_i),
      .busy_o           (busy_o)
`ifdef TRACE_ARB_DROP_COUNT_EN
      ,
      .drop_count_o     (drop_count_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] got,
                      input logic [DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd256();
      logic [DW-1:0] v;
      for (int k = 0; k < DW / 32; k++)
         v[k*32 +: 32] = $urandom();
      return v;
   endfunction

   function automatic logic [N*DW-1:0] pk(input logic [DW-1:0] a,
      input logic [DW-1:0] b, input logic [DW-1:0] c, input logic [DW-1:0] e);
      return {e, c, b, a};
   endfunction

   task automatic m_reset();
      for (int i = 0; i < N; i++) begin
         m_full[i] = 1'b0;
         m_slot[i] = '0;
      end
      m_ov = 1'b0; m_od = '0; m_os = 0; m_ptr = 0; m_ovf = '0;
   endtask

   // Output side frees first, then pulses fill whatever slots are empty.
   task automatic m_step(input logic [N-1:0] rdy, input logic [N*DW-1:0] d,
                         input logic ordy, input logic clr);
      int g;
      g = -1;
      if (!m_ov || ordy) begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (g < 0 && m_full[j]) g = j;
         end
         if (g >= 0) begin
            m_ov = 1'b1; m_od = m_slot[g]; m_os = g;
            m_full[g] = 1'b0; m_ptr = (g + 1) % N;
         end else begin
            m_ov = 1'b0;
         end
      end
      if (clr) m_ovf = '0;
      for (int i = 0; i < N; i++)
         if (rdy[i]) begin
            if (!m_full[i]) begin
               m_full[i] = 1'b1;
               m_slot[i] = d[i*DW +: DW];
            end else begin
               m_ovf[i] = 1'b1;
            end
         end
   endtask

   task automatic compare(input string tag);
      bit any;
      any = m_ov;
      for (int i = 0; i < N; i++) any |= m_full[i];
      chk({tag, "_valid"}, DW'(out_valid_o), DW'(m_ov));
      if (m_ov) begin
         chk({tag, "_data"}, out_data_o, m_od);
         chk({tag, "_src"}, DW'(out_src_o), DW'(m_os));
      end
      chk({tag, "_ovf"}, DW'(overflow_o), DW'(m_ovf));
      chk({tag, "_busy"}, DW'(busy_o), DW'(any));
   endtask

   task automatic step(input string tag, input logic [N-1:0] rdy,
                       input logic [N*DW-1:0] d, input logic ordy,
                       input logic clr);
      req_ready_i = rdy; req_data_i = d;
      out_ready_i = ordy; clear_overflow_i = clr;
      @(posedge clk);
      m_step(rdy, d, ordy, clr);
      #1;
      compare(tag);
   endtask

   task automatic idle(input string tag, input int n, input logic ordy);
      for (int k = 0; k < n; k++) step(tag, '0, '0, ordy, 1'b0);
   endtask

   initial begin
      logic [N*DW-1:0] z;
      z = '0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", DW'(out_valid_o), '0);
      chk("rst_data", out_data_o, '0);
      chk("rst_src", DW'(out_src_o), '0);
      chk("rst_ovf", DW'(overflow_o), '0);
      chk("rst_busy", DW'(busy_o), '0);
      rst = 1'b1;

      // single pulse from requester 2
      step("t1a", 4'b0100, pk(0, 0, 256'hA5, 0), 1'b1, 1'b0);
      step("t1b", '0, z, 1'b1, 1'b0);
      chk("t1_src", DW'(out_src_o), DW'(2));
      chk("t1_data", out_data_o, 256'hA5);
      idle("t1c", 2, 1'b1);

      // all four together
      step("t2a", 4'b1111, pk(256'h10, 256'h11, 256'h12, 256'h13), 1'b1, 1'b0);
      idle("t2b", 6, 1'b1);

      // stalled sink, requester 1 pulses twice behind requester 0
      step("t3a", 4'b0001, pk(256'h01, 0, 0, 0), 1'b0, 1'b0);
      step("t3b", '0, z, 1'b0, 1'b0);
      step("t3c", 4'b0010, pk(0, 256'h21, 0, 0), 1'b0, 1'b0);
      step("t3d", 4'b0010, pk(0, 256'h22, 0, 0), 1'b0, 1'b0);
      idle("t3e", 7, 1'b0);
      chk("t3_ovf1", DW'(overflow_o[1]), DW'(1));
      idle("t3f", 4, 1'b1);
      step("t3g", '0, z, 1'b1, 1'b1);

      // requester 3 refills its slot in the cycle it is granted
      step("t4a", 4'b1000, pk(0, 0, 0, 256'h31), 1'b1, 1'b0);
      step("t4b", 4'b1000, pk(0, 0, 0, 256'h32), 1'b1, 1'b0);
      idle("t4c", 3, 1'b1);
      chk("t4_ovf", DW'(overflow_o), '0);

      // two requesters hammering every cycle
      for (int k = 0; k < 12; k++)
         step("t5", 4'b0101, pk(rnd256(), 0, rnd256(), 0), 1'b1, 1'b0);
      idle("t5z", 4, 1'b1);

      // reset while presenting with two slots full
      step("t6a", 4'b0011, pk(256'h61, 256'h62, 0, 0), 1'b0, 1'b0);
      step("t6b", 4'b0100, pk(0, 0, 256'h63, 0), 1'b0, 1'b0);
      #2 rst = 1'b0;
      #1;
      chk("t6_valid", DW'(out_valid_o), '0);
      chk("t6_data", out_data_o, '0);
      chk("t6_busy", DW'(busy_o), '0);
      m_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      idle("t6c", 5, 1'b1);

      // random traffic
      for (int k = 0; k < 600; k++) begin
         logic [N-1:0] r;
         r = N'($urandom()) & N'($urandom());
         step("rnd", r, pk(rnd256(), rnd256(), rnd256(), rnd256()),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
      end
      idle("drain", 8, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
